alu_issue_stage: RTL

Sequencing stage wrapped around the combinational ALU_TOP in the multicycle processor datapath. It accepts an operation request from the control unit over a valid/ready handshake and selects and latches operands A/B from the register-file outputs, PC, immediate or a constant. It drives ALUSrcA/ALUSrcB/ALUControl for one execute cycle, captures the 33-bit ALUResult into an ALUOut register, derives flags, and returns a response over a second valid/ready handshake.

---
 rtl/alu_issue_stage_if.sv | 48 ++++
 rtl/alu_issue_stage.sv | 135 +++++++++++++
 2 files changed

// File: rtl/alu_issue_stage_if.sv
// Bundle of the request, ALU and response signals around the ALU issue stage.
// The stage itself uses the slave modport; the control unit / ALU side uses master.
interface alu_issue_stage_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    // Request handshake from the control unit
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [1:0]       req_src_a_sel;
    logic [1:0]       req_src_b_sel;
    logic [WIDTH-1:0] req_rs1_data;
    logic [WIDTH-1:0] req_rs2_data;
    logic [WIDTH-1:0] req_pc;
    logic [WIDTH-1:0] req_imm;

    // Connection to the combinational ALU_TOP
    logic [WIDTH-1:0] ALUSrcA;
    logic [WIDTH-1:0] ALUSrcB;
    logic [2:0]       ALUControl;
    logic [WIDTH:0]   ALUResult;

    // Response handshake back to the consumer
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_result;
    logic             resp_carry;
    logic             resp_zero;
    logic             resp_illegal;
    logic [CNT_W-1:0] op_count;

    modport slave (
        input  req_valid, req_op, req_src_a_sel, req_src_b_sel,
               req_rs1_data, req_rs2_data, req_pc, req_imm,
               ALUResult, resp_ready,
        output req_ready, ALUSrcA, ALUSrcB, ALUControl,
               resp_valid, resp_result, resp_carry, resp_zero, resp_illegal, op_count
    );

    modport master (
        output req_valid, req_op, req_src_a_sel, req_src_b_sel,
               req_rs1_data, req_rs2_data, req_pc, req_imm,
               ALUResult, resp_ready,
        input  req_ready, ALUSrcA, ALUSrcB, ALUControl,
               resp_valid, resp_result, resp_carry, resp_zero, resp_illegal, op_count
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue stage: accepts an op request, latches the selected operands, presents
// them to ALU_TOP for exactly one execute cycle, registers the result in ALUOut
// and holds it on the response handshake until it is consumed.
module alu_issue_stage #(
    parameter int WIDTH      = 32,
    parameter int STEP_CONST = 4,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    alu_issue_stage_if.slave    bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_RSVD = 3'b111;

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] a_q,       a_d;
    logic [WIDTH-1:0] b_q,       b_d;
    logic [2:0]       op_q,      op_d;
    logic [WIDTH:0]   alu_out_q, alu_out_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             op_illegal;

    // Operand source muxes; reserved selects read as zero
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        sel_a = '0;
        sel_b = '0;
        case (bus.req_src_a_sel)
            2'b00:   sel_a = bus.req_rs1_data;
            2'b01:   sel_a = bus.req_pc;
            default: sel_a = '0;
        endcase
        case (bus.req_src_b_sel)
            2'b00:   sel_b = bus.req_rs2_data;
            2'b01:   sel_b = WIDTH'(STEP_CONST);
            2'b10:   sel_b = bus.req_imm;
            default: sel_b = '0;
        endcase
    end

    assign op_illegal = (bus.req_op == OP_NONE) || (bus.req_op == OP_RSVD);

    // Next-state and datapath register updates for IDLE -> EXEC -> RESP sequencing
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        alu_out_d = alu_out_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    a_d  = sel_a;
                    b_d  = sel_b;
                    op_d = bus.req_op;
                    if (op_illegal) begin
                        // Illegal ops skip the ALU entirely and answer with a zero result
                        alu_out_d = '0;
                        illegal_d = 1'b1;
                        state_d   = S_RESP;
                    end else begin
                        state_d   = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                alu_out_d = bus.ALUResult;
                illegal_d = 1'b0;
                state_d   = S_RESP;
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset; an in-flight op is simply dropped
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_NONE;
            alu_out_q <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            alu_out_q <= alu_out_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    // ALU drive is gated to the EXEC cycle so ALU_TOP sees zero/000 otherwise
    always_comb begin
        bus.ALUSrcA    = '0;
        bus.ALUSrcB    = '0;
        bus.ALUControl = OP_NONE;
        if (state_q == S_EXEC) begin
            bus.ALUSrcA    = a_q;
            bus.ALUSrcB    = b_q;
            bus.ALUControl = op_q;
        end
    end

    assign bus.req_ready    = (state_q == S_IDLE);
    assign bus.resp_valid   = (state_q == S_RESP);
    assign bus.resp_result  = alu_out_q[WIDTH-1:0];
    assign bus.resp_carry   = alu_out_q[WIDTH];
    assign bus.resp_zero    = (alu_out_q[WIDTH-1:0] == '0);
    assign bus.resp_illegal = illegal_q;
    assign bus.op_count     = cnt_q;

endmodule
